ddr3_ui_responder: RTL and testbench



---
 rtl/ddr3_ui_responder.sv | 160 ++++++++++++++++
 tb/tb_ddr3_ui_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_ui_responder.sv
// ddr3_ui_responder: slave-side model of the MIG DDR3 app interface.
// Provides calibration emulation, a 4-deep in-order command FIFO, and a
// 4-deep write-data FIFO. It is backed by a DATA_WIDTH x 2**DEPTH_LOG2 memory
// with a fixed RD_LATENCY read pipeline and a sticky protocol-error flag.
// Optional: define DDR3_UI_RESP_STALL_EN to add LFSR-driven backpressure on
// app_rdy / app_wdf_rdy.
module ddr3_ui_responder #(
    parameter int ADDR_WIDTH   = 30,
    parameter int DATA_WIDTH   = 256,
    parameter int MASK_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 8,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] app_addr,
    input  logic [2:0]            app_cmd,
    input  logic                  app_en,
    output logic                  app_rdy,
    input  logic [DATA_WIDTH-1:0] app_wdf_data,
    input  logic [MASK_WIDTH-1:0] app_wdf_mask,
    input  logic                  app_wdf_wren,
    input  logic                  app_wdf_end,
    output logic                  app_wdf_rdy,
    output logic [DATA_WIDTH-1:0] app_rd_data,
    output logic                  app_rd_data_valid,
    output logic                  app_rd_data_end,
    output logic                  init_calib_complete,
    output logic                  proto_err
);
    localparam int CW = $clog2(CALIB_CYCLES + 1);

    // Calibration: saturating counter; done once it reaches CALIB_CYCLES-1,
    // which puts the rise exactly CALIB_CYCLES cycles after the last rst cycle.
    logic [CW-1:0] calib_cnt;
    logic          calib;
    assign calib = (calib_cnt == CW'(CALIB_CYCLES - 1));
    assign init_calib_complete = calib;

    // Count calibration cycles from reset release
    always_ff @(posedge clk) begin
        if (rst)        calib_cnt <= '0;
        else if (!calib) calib_cnt <= calib_cnt + 1'b1;
    end

    logic cmd_stall, wdf_stall;
`ifdef DDR3_UI_RESP_STALL_EN
    logic [15:0] lfsr;
    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 used as a backpressure source
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign cmd_stall = (lfsr[1:0] == 2'b00);
    assign wdf_stall = (lfsr[3:2] == 2'b00);
`else
    assign cmd_stall = 1'b0;
    assign wdf_stall = 1'b0;
`endif

    // Command FIFO: read flag + memory index
    logic                  cq_rd  [4];
    logic [DEPTH_LOG2-1:0] cq_idx [4];
    logic [1:0]            cq_wp, cq_rp;
    logic [2:0]            cq_cnt;
    // Write-data FIFO
    logic [DATA_WIDTH-1:0] wq_data [4];
    logic [MASK_WIDTH-1:0] wq_mask [4];
    logic [1:0]            wq_wp, wq_rp;
    logic [2:0]            wq_cnt;

    // Readies depend only on registered state
    assign app_rdy     = calib & (cq_cnt < 3'd4) & ~cmd_stall;
    assign app_wdf_rdy = calib & (wq_cnt < 3'd4) & ~wdf_stall;

    logic cmd_acc, cmd_legal, cq_push, wq_push;
    logic head_vld, head_rd, exec_wr, exec_rd;
    logic [DEPTH_LOG2-1:0] head_idx;

    assign cmd_acc   = app_en & app_rdy;
    assign cmd_legal = (app_cmd == 3'b000) | (app_cmd == 3'b001);
    assign cq_push   = cmd_acc & cmd_legal;
    assign wq_push   = app_wdf_wren & app_wdf_rdy;

    assign head_vld = (cq_cnt != 3'd0);
    assign head_rd  = cq_rd[cq_rp];
    assign head_idx = cq_idx[cq_rp];
    // A write at the head waits for its data; a read always proceeds
    assign exec_wr  = ~rst & head_vld & ~head_rd & (wq_cnt != 3'd0);
    assign exec_rd  = ~rst & head_vld & head_rd;

    // Upper address bits alias and the in-burst offset is ignored
    logic unused_addr;
    assign unused_addr = ^{app_addr[ADDR_WIDTH-1:DEPTH_LOG2+3], app_addr[2:0]};

    // FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            cq_wp <= '0; cq_rp <= '0; cq_cnt <= '0;
            wq_wp <= '0; wq_rp <= '0; wq_cnt <= '0;
        end else begin
            if (cq_push) cq_wp <= cq_wp + 1'b1;
            if (exec_wr | exec_rd) cq_rp <= cq_rp + 1'b1;
            cq_cnt <= cq_cnt + {2'b0, cq_push} - {2'b0, exec_wr | exec_rd};
            if (wq_push) wq_wp <= wq_wp + 1'b1;
            if (exec_wr) wq_rp <= wq_rp + 1'b1;
            wq_cnt <= wq_cnt + {2'b0, wq_push} - {2'b0, exec_wr};
        end
    end

    // FIFO storage (no reset needed; occupancy guards it)
    always_ff @(posedge clk) begin
        if (cq_push) begin
            cq_rd[cq_wp]  <= app_cmd[0];
            cq_idx[cq_wp] <= app_addr[DEPTH_LOG2+2:3];
        end
        if (wq_push) begin
            wq_data[wq_wp] <= app_wdf_data;
            wq_mask[wq_wp] <= app_wdf_mask;
        end
    end

    // Backing memory: byte-masked writes, contents kept across rst
    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
    always_ff @(posedge clk) begin
        if (exec_wr)
            for (int b = 0; b < MASK_WIDTH; b++)
                if (!wq_mask[wq_rp][b])
                    mem[head_idx][b*8 +: 8] <= wq_data[wq_rp][b*8 +: 8];
    end

    // Read pipeline: stage 0 captures memory in the issue cycle
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [DATA_WIDTH-1:0] rd_pipe [RD_LATENCY];
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) rd_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= exec_rd;
            if (exec_rd) rd_pipe[0] <= mem[head_idx];
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                rd_pipe[i]  <= rd_pipe[i-1];
            end
        end
    end
    assign app_rd_data       = rd_pipe[RD_LATENCY-1];
    assign app_rd_data_valid = vld_pipe[RD_LATENCY-1];
    assign app_rd_data_end   = vld_pipe[RD_LATENCY-1];

    // Sticky protocol-error flag
    always_ff @(posedge clk) begin
        if (rst) proto_err <= 1'b0;
        else if ((cmd_acc & ~cmd_legal) | (app_wdf_wren != app_wdf_end) |
                 (app_en & ~calib))
            proto_err <= 1'b1;
    end
endmodule

// File: tb/tb_ddr3_ui_responder.sv
// Scoreboard bench for ddr3_ui_responder: expected read beats are queued at
// issue time and a negedge monitor pops and compares every valid beat.
module tb_ddr3_ui_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [29:0]  app_addr = '0;
    logic [2:0]   app_cmd = '0;
    logic         app_en = 1'b0;
    logic         app_rdy;
    logic [255:0] app_wdf_data = '0;
    logic [31:0]  app_wdf_mask = '0;
    logic         app_wdf_wren = 1'b0;
    logic         app_wdf_end = 1'b0;
    logic         app_wdf_rdy;
    logic [255:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         init_calib_complete;
    logic         proto_err;

    int vectors = 0;
    int miscompares = 0;
    logic [255:0] exp_q[$];

    ddr3_ui_responder dut (
        .clk(clk), .rst(rst), .app_addr(app_addr), .app_cmd(app_cmd),
        .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end),
        .init_calib_complete(init_calib_complete), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid beat must match the oldest expected beat
    always @(negedge clk) begin
        if (app_rd_data_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", 256'(app_rd_data_valid), 256'd0);
            end else begin
                chk("rd_data", app_rd_data, exp_q.pop_front());
                chk("rd_end", 256'(app_rd_data_end), 256'd1);
            end
        end
    end

    task automatic cmd_issue(input logic [2:0] c, input logic [29:0] a);
        int n = 0;
        app_en = 1'b1; app_cmd = c; app_addr = a;
        while (!app_rdy && n < 200) begin tick(); n++; end
        if (n >= 200) chk("cmd_accept_timeout", 256'(n), 256'd0);
        tick();
        app_en = 1'b0;
    endtask

    task automatic wdf_issue(input logic [255:0] d, input logic [31:0] m);
        int n = 0;
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m;
        while (!app_wdf_rdy && n < 200) begin tick(); n++; end
        if (n >= 200) chk("wdf_accept_timeout", 256'(n), 256'd0);
        tick();
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    endtask

    task automatic wait_drain;
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin tick(); n++; end
        chk("drain", 256'(exp_q.size()), 256'd0);
    endtask

    // One rst cycle, then return at the first post-reset cycle
    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_calib;
        repeat (63) tick();
        chk("recalib_done", 256'(init_calib_complete), 256'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] ones;
        logic [255:0] d;
        int cnt;
        int n;
        ones = '1;

        // Calibration and reset values
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_rdy", 256'(app_rdy), 256'd0);
        chk("rst_wdf_rdy", 256'(app_wdf_rdy), 256'd0);
        chk("rst_rd_data", app_rd_data, 256'd0);
        chk("rst_valid", 256'({app_rd_data_valid, app_rd_data_end}), 256'd0);
        chk("rst_calib", 256'(init_calib_complete), 256'd0);
        chk("rst_err", 256'(proto_err), 256'd0);
        repeat (62) tick();
        chk("calib_pre", 256'(init_calib_complete), 256'd0);
        chk("rdy_pre", 256'(app_rdy), 256'd0);
        tick();
        chk("calib_at_64", 256'(init_calib_complete), 256'd1);
        chk("rdy_post", 256'({app_rdy, app_wdf_rdy}), 256'd3);

        // Write then read addr 0x40; check read latency
        wdf_issue({32{8'hA5}}, 32'h0);
        cmd_issue(3'b000, 30'h40);
        exp_q.push_back({32{8'hA5}});
        cmd_issue(3'b001, 30'h40);
        for (int j = 1; j <= 4; j++) begin
            chk("rd_lat_quiet", 256'(app_rd_data_valid), 256'd0);
            if (j < 4) tick();
        end
        tick();
        chk("rd_lat_5", 256'({app_rd_data_valid, app_rd_data_end}), 256'd3);
        wait_drain();

        // Byte masking
        wdf_issue(ones, 32'h0);
        cmd_issue(3'b000, 30'h0);
        wdf_issue(256'd0, 32'hFFFF_FFFE);
        cmd_issue(3'b000, 30'h0);
        exp_q.push_back({{31{8'hFF}}, 8'h00});
        cmd_issue(3'b001, 30'h0);
        wait_drain();

        // Backpressure: 4 writes without data fill the command FIFO
        for (int i = 0; i < 4; i++) cmd_issue(3'b000, 30'((10 + i) * 8));
        chk("rdy_full", 256'(app_rdy), 256'd0);
        tick();
        chk("rdy_full_hold", 256'(app_rdy), 256'd0);
        fork
            begin
                for (int i = 4; i < 6; i++) cmd_issue(3'b000, 30'((10 + i) * 8));
            end
            begin
                for (int i = 0; i < 6; i++) wdf_issue({8{32'hC0DE_0000 | 32'(i)}}, 32'h0);
            end
        join
        repeat (10) tick();
        for (int i = 0; i < 6; i++) exp_q.push_back({8{32'hC0DE_0000 | 32'(i)}});
        fork
            begin
                for (int i = 0; i < 6; i++) cmd_issue(3'b001, 30'((10 + i) * 8));
            end
            begin
                n = 0;
                while (!app_rd_data_valid && n < 40) begin tick(); n++; end
                cnt = 0;
                while (app_rd_data_valid && cnt < 20) begin tick(); cnt++; end
                chk("rd_contig", 256'(cnt), 256'd6);
            end
        join
        wait_drain();

        // Illegal command
        chk("err_clear", 256'(proto_err), 256'd0);
        cmd_issue(3'b010, 30'h40);
        chk("err_illegal", 256'(proto_err), 256'd1);
        repeat (10) tick();
        do_reset();
        chk("err_rst", 256'(proto_err), 256'd0);
        wait_calib();

        // Write-data strobe without end
        app_wdf_wren = 1'b1; app_wdf_end = 1'b0;
        tick();
        app_wdf_wren = 1'b0;
        chk("err_wren_end", 256'(proto_err), 256'd1);
        do_reset();
        chk("err_rst2", 256'(proto_err), 256'd0);
        wait_calib();

        // Reset with reads in flight: nothing emerges, memory retained
        for (int i = 0; i < 3; i++) cmd_issue(3'b001, 30'h0);
        do_reset();
        for (int k = 0; k < 63; k++) begin
            if (app_rd_data_valid || init_calib_complete)
                chk("recal_quiet", 256'({app_rd_data_valid, init_calib_complete}), 256'd0);
            tick();
        end
        chk("recal_quiet_end", 256'(app_rd_data_valid), 256'd0);
        chk("recal_done", 256'(init_calib_complete), 256'd1);
        d = {{31{8'hFF}}, 8'h00};
        exp_q.push_back(d);
        cmd_issue(3'b001, 30'h0);
        wait_drain();
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
